// File: rtl/gb_host_arbiter.sv
// gb_host_arbiter: two-requester round-robin arbiter for the ghostbus host port.
// Serialises single read/write transactions into one-cycle gb_wen/gb_rstb strobes.
//
// Ports:
//   gb_clk, gb_rst           clock, asynchronous active-high reset
//   reqN_valid/we/addr/wdata requester N transaction request (N = 0, 1)
//   reqN_ack                 one-cycle completion pulse
//   reqN_rdata               read result, held until that requester's next read
//   gb_addr/gb_wdata         registered ghostbus address / write data
//   gb_wen/gb_rstb           ghostbus write / read strobes (high only in STROBE)
//   gb_rdata                 ghostbus read data, valid RD_DELAY cycles after gb_rstb
//   busy                     high whenever the arbiter is not idle
module gb_host_arbiter #(
    parameter int GB_AW    = 24,
    parameter int GB_DW    = 32,
    parameter int RD_DELAY = 2
) (
    input  logic             gb_clk,
    input  logic             gb_rst,
    input  logic             req0_valid,
    input  logic             req0_we,
    input  logic [GB_AW-1:0] req0_addr,
    input  logic [GB_DW-1:0] req0_wdata,
    output logic             req0_ack,
    output logic [GB_DW-1:0] req0_rdata,
    input  logic             req1_valid,
    input  logic             req1_we,
    input  logic [GB_AW-1:0] req1_addr,
    input  logic [GB_DW-1:0] req1_wdata,
    output logic             req1_ack,
    output logic [GB_DW-1:0] req1_rdata,
    output logic [GB_AW-1:0] gb_addr,
    output logic [GB_DW-1:0] gb_wdata,
    output logic             gb_wen,
    output logic             gb_rstb,
    input  logic [GB_DW-1:0] gb_rdata,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        RWAIT  = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(RD_DELAY - 1);
    localparam bit         RD_FAST  = (RD_DELAY == 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       last_grant;
    logic       sel;
    logic       we_q;
    logic       any_req;
    logic       win;
    logic       capture;

    // On a tie the requester not granted last wins; otherwise the lone one.
    assign any_req = req0_valid | req1_valid;
    assign win     = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

    // Read data is sampled in the last cycle before ACK.
    assign capture = (state == STROBE && !we_q && RD_FAST) ||
                     (state == RWAIT && cnt == 4'd1);

    // State register
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = STROBE;
            STROBE: begin
                if (we_q || RD_FAST) state_nxt = ACK;
                else                 state_nxt = RWAIT;
            end
            RWAIT:   if (cnt == 4'd1) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            sel        <= 1'b0;
            we_q       <= 1'b0;
            gb_addr    <= '0;
            gb_wdata   <= '0;
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                sel      <= win;
                we_q     <= win ? req1_we    : req0_we;
                gb_addr  <= win ? req1_addr  : req0_addr;
                gb_wdata <= win ? req1_wdata : req0_wdata;
            end
            if (state == STROBE && !we_q) cnt <= CNT_LOAD;
            if (state == RWAIT)           cnt <= cnt - 4'd1;
            if (capture) begin
                if (sel) req1_rdata <= gb_rdata;
                else     req0_rdata <= gb_rdata;
            end
            if (state == ACK) last_grant <= sel;
        end
    end

    // Outputs decoded from state so an async reset drops them at once
    always_comb begin
        gb_wen   = (state == STROBE) &  we_q;
        gb_rstb  = (state == STROBE) & ~we_q;
        req0_ack = (state == ACK) & ~sel;
        req1_ack = (state == ACK) &  sel;
        busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_gb_host_arbiter.sv
// tb_gb_host_arbiter: directed self-checking bench for gb_host_arbiter.
// Main instance uses RD_DELAY=2; two extra instances cover RD_DELAY=1 and 15.
module tb_gb_host_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int RD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req0_valid = 0, req0_we = 0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 0, req1_we = 0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req0_ack, req1_ack, gb_wen, gb_rstb, busy;
    logic [DW-1:0] req0_rdata, req1_rdata, gb_wdata, gb_rdata;
    logic [AW-1:0] gb_addr;

    logic [DW-1:0] rd_val = '0;
    logic [7:0]    kreg = 8'hFF;

    int tests = 0;
    int fails = 0;
    int ovl   = 0;
    bit ack_log[$];

    gb_host_arbiter #(.GB_AW(AW), .GB_DW(DW), .RD_DELAY(RD)) dut (
        .gb_clk(clk), .gb_rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ack(req0_ack), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ack(req1_ack), .req1_rdata(req1_rdata),
        .gb_addr(gb_addr), .gb_wdata(gb_wdata),
        .gb_wen(gb_wen), .gb_rstb(gb_rstb),
        .gb_rdata(gb_rdata), .busy(busy)
    );

    // Bus model: read data is only correct in cycle T+RD-1 after the strobe
    always @(posedge clk)
        kreg <= gb_rstb ? 8'd1 : (kreg == 8'hFF ? kreg : kreg + 8'd1);
    assign gb_rdata = ((gb_rstb ? 8'd0 : kreg) == 8'(RD - 1)) ?
                      rd_val : 32'hBAD00000;

    always @(posedge clk) begin
        if (req0_ack) ack_log.push_back(1'b0);
        if (req1_ack) ack_log.push_back(1'b1);
        if (gb_wen && gb_rstb) ovl <= ovl + 1;
    end

    // Latency instances: index 0 -> RD_DELAY=1, index 1 -> RD_DELAY=15
    logic          lv [2];
    logic          lack [2];
    logic [DW-1:0] lrd [2];
    logic [DW-1:0] lgbr [2];
    logic          lstb [2];
    logic [7:0]    lk [2];
    logic          lack1 [2], lwen [2], lbusy [2];
    logic [DW-1:0] lrd1 [2], lwd [2];
    logic [AW-1:0] lad [2];

    initial begin
        lv[0] = 0; lv[1] = 0;
        lk[0] = 8'hFF; lk[1] = 8'hFF;
    end

    always @(posedge clk)
        for (int i = 0; i < 2; i++)
            lk[i] <= lstb[i] ? 8'd1 : (lk[i] == 8'hFF ? lk[i] : lk[i] + 8'd1);

    always_comb
        for (int i = 0; i < 2; i++)
            lgbr[i] = {16'hC0DE, 8'h00, (lstb[i] ? 8'd0 : lk[i])};

    gb_host_arbiter #(.GB_AW(AW), .GB_DW(DW), .RD_DELAY(1)) dut_d1 (
        .gb_clk(clk), .gb_rst(rst),
        .req0_valid(lv[0]), .req0_we(1'b0),
        .req0_addr(24'h0), .req0_wdata(32'h0),
        .req0_ack(lack[0]), .req0_rdata(lrd[0]),
        .req1_valid(1'b0), .req1_we(1'b0),
        .req1_addr(24'h0), .req1_wdata(32'h0),
        .req1_ack(lack1[0]), .req1_rdata(lrd1[0]),
        .gb_addr(lad[0]), .gb_wdata(lwd[0]),
        .gb_wen(lwen[0]), .gb_rstb(lstb[0]),
        .gb_rdata(lgbr[0]), .busy(lbusy[0])
    );

    gb_host_arbiter #(.GB_AW(AW), .GB_DW(DW), .RD_DELAY(15)) dut_d15 (
        .gb_clk(clk), .gb_rst(rst),
        .req0_valid(lv[1]), .req0_we(1'b0),
        .req0_addr(24'h0), .req0_wdata(32'h0),
        .req0_ack(lack[1]), .req0_rdata(lrd[1]),
        .req1_valid(1'b0), .req1_we(1'b0),
        .req1_addr(24'h0), .req1_wdata(32'h0),
        .req1_ack(lack1[1]), .req1_rdata(lrd1[1]),
        .gb_addr(lad[1]), .gb_wdata(lwd[1]),
        .gb_wen(lwen[1]), .gb_rstb(lstb[1]),
        .gb_rdata(lgbr[1]), .busy(lbusy[1])
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for requester n's ack (bounded); drop its valid in the ack cycle.
    task automatic wait_ack(input bit n, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(n ? req1_ack : req0_ack) && lat < 40);
        chk(n ? "ack1_seen" : "ack0_seen", n ? req1_ack : req0_ack, 1);
        if (n) req1_valid = 0;
        else   req0_valid = 0;
    endtask

    function automatic logic [7:0] order(input int base, input int n);
        logic [7:0] o;
        o = '0;
        for (int i = 0; i < n; i++)
            if (base + i < ack_log.size()) o[i] = ack_log[base + i];
        return o;
    endfunction

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int lat;
        int base;
        int c;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_addr", gb_addr, 0);
        chk("rst_wdata", gb_wdata, 0);
        chk("rst_strobes", {gb_wen, gb_rstb}, 0);
        chk("rst_acks", {req0_ack, req1_ack}, 0);
        chk("rst_rdata", {req0_rdata, req1_rdata}, 0);
        chk("rst_busy", busy, 0);
        rst = 0;
        @(negedge clk);

        // Single write from requester 0
        req0_valid = 1; req0_we = 1;
        req0_addr = 24'h000010; req0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_wen", gb_wen, 1);
        chk("wr_rstb", gb_rstb, 0);
        chk("wr_addr", gb_addr, 24'h000010);
        chk("wr_wdata", gb_wdata, 32'hDEADBEEF);
        chk("wr_busy", busy, 1);
        chk("wr_ack_early", req0_ack, 0);
        @(negedge clk);
        chk("wr_wen_once", gb_wen, 0);
        chk("wr_ack0", req0_ack, 1);
        chk("wr_ack1", req1_ack, 0);
        chk("wr_busy_ack", busy, 1);
        req0_valid = 0;
        @(negedge clk);
        chk("wr_ack_drop", req0_ack, 0);
        chk("wr_idle", busy, 0);

        // Single read from requester 1
        rd_val = 32'h12345678;
        req1_valid = 1; req1_we = 0; req1_addr = 24'h000020;
        @(negedge clk);
        chk("rd_rstb", gb_rstb, 1);
        chk("rd_wen", gb_wen, 0);
        chk("rd_addr", gb_addr, 24'h000020);
        wait_ack(1, lat);
        chk("rd_lat", lat, 2);
        chk("rd_data1", req1_rdata, 32'h12345678);
        chk("rd_data0", req0_rdata, 0);
        @(negedge clk);
        chk("rd_ack_drop", req1_ack, 0);

        // Simultaneous requests from reset
        rst_pulse();
        base = ack_log.size();
        rd_val = 32'hA5A50002;
        req0_we = 1; req0_addr = 24'h1; req0_wdata = 32'h11;
        req1_we = 0; req1_addr = 24'h2;
        req0_valid = 1; req1_valid = 1;
        wait_ack(0, lat);
        chk("sim_lat0", lat, 2);
        wait_ack(1, lat);
        chk("sim_lat1", lat, 4);
        chk("sim_rdata1", req1_rdata, 32'hA5A50002);
        @(negedge clk);
        req0_valid = 1; req1_valid = 1;
        wait_ack(0, lat);
        chk("sim2_lat0", lat, 2);
        wait_ack(1, lat);
        chk("sim2_lat1", lat, 4);
        repeat (2) @(negedge clk);
        chk("sim_count", ack_log.size() - base, 4);
        chk("sim_order", order(base, 4), 8'b0000_1010);

        // Continuous contention: writes from 0, reads from 1
        rst_pulse();
        base = ack_log.size();
        rd_val = 32'h0BADCAFE;
        req0_we = 1; req0_addr = 24'h3; req0_wdata = 32'h33;
        req1_we = 0; req1_addr = 24'h4;
        req0_valid = 1; req1_valid = 1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (ack_log.size() - base < 8 && c < 200);
        req0_valid = 0; req1_valid = 0;
        chk("cont_cycles", c, 28);
        repeat (6) @(negedge clk);
        chk("cont_acks", ack_log.size() - base, 8);
        chk("cont_order", order(base, 8), 8'b1010_1010);
        chk("cont_rdata1", req1_rdata, 32'h0BADCAFE);

        // Reset asserted during RWAIT
        rst_pulse();
        base = ack_log.size();
        rd_val = 32'hCAFEF00D;
        req0_we = 0; req0_addr = 24'h40;
        req0_valid = 1;
        @(negedge clk);
        chk("rr_rstb", gb_rstb, 1);
        @(negedge clk);
        chk("rr_busy", busy, 1);
        #1 rst = 1;
        #1;
        chk("rr_async_rstb", gb_rstb, 0);
        chk("rr_async_busy", busy, 0);
        chk("rr_async_acks", {req0_ack, req1_ack}, 0);
        chk("rr_async_addr", gb_addr, 0);
        chk("rr_async_rdata", req0_rdata, 0);
        @(negedge clk);
        chk("rr_no_ack", ack_log.size() - base, 0);
        rd_val = 32'h600DF00D;
        rst = 0;
        wait_ack(0, lat);
        chk("rr_lat", lat, 3);
        chk("rr_rdata", req0_rdata, 32'h600DF00D);
        @(negedge clk);
        chk("rr_one_ack", ack_log.size() - base, 1);

        // RD_DELAY=1 and RD_DELAY=15 instances
        for (int i = 0; i < 2; i++) begin
            int d;
            d = (i == 0) ? 1 : 15;
            @(negedge clk);
            lv[i] = 1;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!lack[i] && lat < 40);
            lv[i] = 0;
            chk(i == 0 ? "d1_ack" : "d15_ack", lack[i], 1);
            chk(i == 0 ? "d1_lat" : "d15_lat", lat, d + 1);
            chk(i == 0 ? "d1_data" : "d15_data", lrd[i],
                {16'hC0DE, 16'(d - 1)});
        end

        @(negedge clk);
        chk("no_overlap", ovl, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gb_host_arbiter.md
# gb_host_arbiter

Two-requester round-robin arbiter that shares the single ghostbus host port (gb_addr/gb_wdata/gb_wen/gb_rstb/gb_rdata) between two independent bus masters. Each master issues single read or write transactions over a valid/ack handshake. The arbiter serialises them into one-cycle ghostbus strobes and returns read data after a fixed read latency. It sits between the host-side masters and the top-level ghostbus decode tree.

## Interface
- GB_AW, 24, ghostbus address width
- GB_DW, 32, ghostbus data width
- RD_DELAY, 2, cycles from gb_rstb assertion to valid gb_rdata; legal range 1..15

- gb_clk  input  1  bus clock; all logic on posedge
- gb_rst  input  1  reset; asynchronous, active-high
- req0_valid  input  1  requester 0 transaction pending
- req0_we  input  1  1 = write, 0 = read
- req0_addr  input  GB_AW  requester 0 address
- req0_wdata  input  GB_DW  requester 0 write data
- req0_ack  output  1  one-cycle completion pulse
- req0_rdata  output  GB_DW  read result, valid when req0_ack is high for a read
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ack, req1_rdata: identical set for requester 1
- gb_addr  output  GB_AW  ghostbus address
- gb_wdata  output  GB_DW  ghostbus write data
- gb_wen  output  1  ghostbus write strobe
- gb_rstb  output  1  ghostbus read strobe
- gb_rdata  input  GB_DW  ghostbus read data
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, STROBE, RWAIT, ACK.
- IDLE: if any reqN_valid is high, select the winner, register its addr/wdata/we and its index, then go to STROBE. Otherwise stay in IDLE.
- Arbitration:
  - Only one valid requester: it wins.
  - Both valid: the requester not granted last wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- STROBE: for one cycle, drive gb_wen = we or gb_rstb = ~we, with gb_addr/gb_wdata carrying the registered values.
  - Write: go to ACK.
  - Read: load a 4-bit counter with RD_DELAY-1 and go to RWAIT. With RD_DELAY = 1, go directly to ACK and capture gb_rdata at the end of STROBE.
- RWAIT: decrement the counter. When it reaches 0, capture gb_rdata into the granted requester's reqN_rdata register and go to ACK.
- ACK: pulse the granted reqN_ack for one cycle, update last_grant, then go to IDLE.
- Requester rules:
  - Hold valid and the fields stable until ack.
  - Fields are sampled only in the IDLE grant cycle; later changes do not affect the transaction in flight.
  - Dropping valid after grant does not cancel the transaction; ack still pulses.
  - The requester must deassert valid in the ack cycle, or a new transaction is issued.
- reqN_rdata holds its value until that requester's next read completes. Writes do not modify it.
- gb_addr/gb_wdata hold their last values between transactions. gb_wen/gb_rstb are low outside STROBE and are never high together.

## Timing
- Reset values: every output 0 (gb_addr, gb_wdata, gb_wen, gb_rstb, both ack, both rdata, busy), state IDLE, counter 0, last_grant 1.
- Reset is asynchronous and takes effect mid-transaction: the strobe drops immediately, the transaction is abandoned with no ack, and the requester must re-issue.
- Valid sampled in IDLE at edge E. The strobe is high in cycle E+1 (call it T).
- Write: ack high in cycle T+1, IDLE in T+2. Back-to-back period is 3 cycles.
- Read: gb_rdata is sampled at the end of cycle T+RD_DELAY-1, and ack plus rdata are valid in cycle T+RD_DELAY.
  - With the default RD_DELAY = 2, ack arrives in T+2.
  - Period is RD_DELAY+2 cycles.
- busy is high from T through the ack cycle inclusive.
- Under continuous contention, grants alternate 0,1,0,1. Neither requester waits more than one other transaction.

## Test plan
- Reset then single write: req0 write addr 0x000010, data 0xDEADBEEF → gb_wen high for exactly 1 cycle with gb_addr = 0x000010, gb_wdata = 0xDEADBEEF; req0_ack one cycle later; req1_ack stays 0.
- Single read, RD_DELAY = 2: req1 read 0x000020, bench returns gb_rdata = 0x12345678 two cycles after gb_rstb → req1_ack in the cycle T+2 with req1_rdata = 0x12345678; req0_rdata stays 0.
- Simultaneous requests from reset: both valid (req0 write 0x1, req1 read 0x2) → req0 served first, then req1; a second simultaneous pair grants req0 next, because req1 was granted last.
- Continuous contention for 8 transactions → grant order alternates 0,1,0,1…, 8 acks total, and gb_wen/gb_rstb are never high in the same cycle.
- Reset asserted during RWAIT → all outputs 0 asynchronously with no ack; after release, the re-issued read completes normally with the correct data.
- RD_DELAY = 1 and RD_DELAY = 15 builds → ack latency after the strobe equals RD_DELAY and the correct data is captured.
